// File: rtl/serial_deser_pkg.sv
// serial_deser_pkg: shared types and constants for the serial_deser receiver.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package serial_deser_pkg;

    // Receiver FSM states; PAR is only reachable when SERIAL_DESER_PARITY_EN is defined.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_PAR  = 2'd2,
        ST_STOP = 2'd3
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

    // Serial line levels.
    localparam logic LINE_IDLE  = 1'b1;
    localparam logic LINE_START = 1'b0;
    localparam logic LINE_STOP  = 1'b1;

endpackage

// File: rtl/serial_deser.sv
// serial_deser: start/stop-framed serial receiver, LSB-first, optional even parity.
// Latency: word and error pulses are registered and visible right after the stop-bit edge.
// Backpressure: valid/ready holding register; a word completing while it is full is dropped with an overrun pulse.
//
// Ports:
//   i_clk, i_rst        rising-edge clock, synchronous active-high reset
//   i_din               serial line (idle 1, start 0, data LSB first, [parity], stop 1)
//   o_dout/o_dout_valid received word and its valid, held stable until i_dout_ready
//   i_dout_ready        consumer accepts the word when o_dout_valid && i_dout_ready
//   o_frame_err         one-cycle pulse: stop bit sampled 0
//   o_par_err           one-cycle pulse: even-parity mismatch (tied 0 without parity)
//   o_overrun           one-cycle pulse: completed word dropped, holding register full
//
// Build option: define SERIAL_DESER_PARITY_EN to expect one even-parity bit after the data bits.
module serial_deser
    import serial_deser_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_din,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_dout_valid,
    input  logic             i_dout_ready,
    output logic             o_frame_err,
    output logic             o_par_err,
    output logic             o_overrun
);

    localparam int               CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]    LAST = CW'(WIDTH - 1);

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] r_dout;
    logic             r_dout_valid;
    logic             r_frame_err;
    logic             r_overrun;

    state_t           w_state_nxt;
    logic [CW-1:0]    w_cnt_nxt;
    logic [WIDTH-1:0] w_shift_nxt;
    logic [WIDTH-1:0] w_dout_nxt;
    logic             w_dout_valid_nxt;
    logic             w_frame_err_nxt;
    logic             w_overrun_nxt;

`ifdef SERIAL_DESER_PARITY_EN
    logic r_par_bad;
    logic r_par_err;
    logic w_par_bad_nxt;
    logic w_par_err_nxt;
`endif

    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_shift_nxt      = r_shift;
        w_dout_nxt       = r_dout;
        // A handshake drains the holding register unless a new word lands below.
        w_dout_valid_nxt = r_dout_valid && !i_dout_ready;
        w_frame_err_nxt  = 1'b0;
        w_overrun_nxt    = 1'b0;
`ifdef SERIAL_DESER_PARITY_EN
        w_par_bad_nxt    = r_par_bad;
        w_par_err_nxt    = 1'b0;
`endif

        case (r_state)
            ST_IDLE: begin
                if (i_din == LINE_START) begin
                    w_state_nxt = ST_DATA;
                    w_cnt_nxt   = '0;
`ifdef SERIAL_DESER_PARITY_EN
                    w_par_bad_nxt = 1'b0;
`endif
                end
            end

            ST_DATA: begin
                w_shift_nxt[r_cnt] = i_din;
                if (r_cnt == LAST) begin
                    w_cnt_nxt = '0;
`ifdef SERIAL_DESER_PARITY_EN
                    w_state_nxt = ST_PAR;
`else
                    w_state_nxt = ST_STOP;
`endif
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end

`ifdef SERIAL_DESER_PARITY_EN
            ST_PAR: begin
                // Even parity: the parity bit equals the XOR of the data bits.
                w_par_bad_nxt = (i_din != (^r_shift));
                w_state_nxt   = ST_STOP;
            end
`endif

            ST_STOP: begin
                w_state_nxt = ST_IDLE;
                if (i_din != LINE_STOP) begin
                    w_frame_err_nxt = 1'b1;
`ifdef SERIAL_DESER_PARITY_EN
                end else if (r_par_bad) begin
                    w_par_err_nxt = 1'b1;
`endif
                end else if (!r_dout_valid || i_dout_ready) begin
                    // Empty, or being drained on this very edge: the new word takes its place.
                    w_dout_nxt       = r_shift;
                    w_dout_valid_nxt = 1'b1;
                end else begin
                    w_overrun_nxt = 1'b1;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_shift      <= '0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overrun    <= 1'b0;
`ifdef SERIAL_DESER_PARITY_EN
            r_par_bad    <= 1'b0;
            r_par_err    <= 1'b0;
`endif
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_shift      <= w_shift_nxt;
            r_dout       <= w_dout_nxt;
            r_dout_valid <= w_dout_valid_nxt;
            r_frame_err  <= w_frame_err_nxt;
            r_overrun    <= w_overrun_nxt;
`ifdef SERIAL_DESER_PARITY_EN
            r_par_bad    <= w_par_bad_nxt;
            r_par_err    <= w_par_err_nxt;
`endif
        end
    end

    assign o_dout       = r_dout;
    assign o_dout_valid = r_dout_valid;
    assign o_frame_err  = r_frame_err;
    assign o_overrun    = r_overrun;
`ifdef SERIAL_DESER_PARITY_EN
    assign o_par_err    = r_par_err;
`else
    assign o_par_err    = 1'b0;
`endif

endmodule
